// File: rtl/rcc_pkg.sv
// Shared definitions for the RC-sensor scan controller and its datapaths.
package rcc_pkg;

  // Scan sequencer state encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHARGE = 2'd1;
  localparam logic [1:0] ST_SENSE  = 2'd2;
  localparam logic [1:0] ST_NEXT   = 2'd3;

  // Count clock source select for the datapath tick mux.
  typedef enum logic [1:0] {
    TSEL_N100 = 2'd0,
    TSEL_U1   = 2'd1,
    TSEL_U10  = 2'd2,
    TSEL_U100 = 2'd3
  } tsel_e;

endpackage

// File: rtl/rcc_next_bank.sv
// Finds the next enabled sensor bank: the lowest enabled bank when first_i is
// set, otherwise the lowest enabled bank strictly above bank_i (no wrap).
module rcc_next_bank #(
  parameter  int NBANK = 4,
  localparam int BW    = $clog2(NBANK)
) (
  input  logic [NBANK-1:0] cfg_mask_i,
  input  logic [BW-1:0]    bank_i,
  input  logic             first_i,
  output logic [BW-1:0]    bank_o,
  output logic             valid_o
);

  logic [NBANK-1:0] cand;

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_cand
    assign cand[gi] = cfg_mask_i[gi] & (first_i | (BW'(gi) > bank_i));
  end

  // Priority-encode the lowest candidate; scanning downwards lets the lowest win.
  always_comb begin
    bank_o  = '0;
    valid_o = 1'b0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (cand[i]) begin
        bank_o  = BW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rcc_scan_ctl.sv
// Poll timer and charge/sense sequencer for a bank of RC-sensor datapaths.
// Visits each enabled bank round-robin, raises per-bank avail flags and
// sticky overrun flags for banks that complete again before being acked.
module rcc_scan_ctl
  import rcc_pkg::*;
#(
  parameter  int NBANK     = 4,
  parameter  int CNTW      = 8,
  parameter  int CHG_TICKS = 1,
  localparam int BW        = $clog2(NBANK)
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             m10_tick,
  input  logic             u10_tick,
  input  logic             cnt_tick,
  input  logic [3:0]       cfg_poll,
  input  logic [NBANK-1:0] cfg_mask,
  input  logic             bank_alldone,
  input  logic [NBANK-1:0] host_ack,
  output logic [BW-1:0]    bank_sel,
  output logic             charge,
  output logic             sensing,
  output logic [CNTW-1:0]  count,
  output logic [NBANK-1:0] avail,
  output logic [NBANK-1:0] overrun,
  output logic             busy
);

  localparam logic [3:0]      CHG_LAST = 4'(CHG_TICKS - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       pollcnt_q, pollcnt_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic [3:0]       chg_q, chg_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [NBANK-1:0] avail_q, avail_d;
  logic [NBANK-1:0] overrun_q, overrun_d;
  logic             charge_q, sensing_q;
  logic [BW-1:0]    nb_bank;
  logic             nb_valid;
  logic             bank_done;

  // From IDLE the finder returns the lowest enabled bank, otherwise the next one up.
  rcc_next_bank #(.NBANK(NBANK)) u_next_bank (
    .cfg_mask_i (cfg_mask),
    .bank_i     (bank_q),
    .first_i    (state_q == ST_IDLE),
    .bank_o     (nb_bank),
    .valid_o    (nb_valid)
  );

  // Next-state logic for the poll timer, sequencer and per-bank flags.
  always_comb begin
    state_d   = state_q;
    pollcnt_d = pollcnt_q;
    bank_d    = bank_q;
    chg_d     = chg_q;
    count_d   = count_q;
    avail_d   = avail_q & ~host_ack;
    overrun_d = overrun_q & ~host_ack;
    bank_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m10_tick && (cfg_poll != 4'd0) && (cfg_mask != '0)) begin
          if (pollcnt_q == cfg_poll) begin
            pollcnt_d = 4'd1;
            bank_d    = nb_bank;
            chg_d     = 4'd0;
            state_d   = ST_CHARGE;
          end else begin
            // Free-running 4-bit wrap lets a lowered cfg_poll still be reached.
            pollcnt_d = pollcnt_q + 4'd1;
          end
        end
      end
      ST_CHARGE: begin
        if (u10_tick) begin
          if (chg_q == CHG_LAST) begin
            count_d = '0;
            state_d = ST_SENSE;
          end else begin
            chg_d = chg_q + 4'd1;
          end
        end
      end
      ST_SENSE: begin
        // All pins crossing ends the bank early and freezes the count.
        if (bank_alldone) begin
          bank_done = 1'b1;
        end else if (cnt_tick) begin
          if (count_q == CNT_MAX) bank_done = 1'b1;
          else                    count_d   = count_q + 1'b1;
        end
        if (bank_done) begin
          avail_d[bank_q] = 1'b1;
          if (avail_q[bank_q] && !host_ack[bank_q]) overrun_d[bank_q] = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (nb_valid && (cfg_poll != 4'd0)) begin
          bank_d  = nb_bank;
          chg_d   = 4'd0;
          state_d = ST_CHARGE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; charge/sensing are decoded from the next state so they are registered.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q   <= ST_IDLE;
      pollcnt_q <= 4'd1;
      bank_q    <= '0;
      chg_q     <= 4'd0;
      count_q   <= '0;
      avail_q   <= '0;
      overrun_q <= '0;
      charge_q  <= 1'b0;
      sensing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pollcnt_q <= pollcnt_d;
      bank_q    <= bank_d;
      chg_q     <= chg_d;
      count_q   <= count_d;
      avail_q   <= avail_d;
      overrun_q <= overrun_d;
      charge_q  <= (state_d == ST_CHARGE);
      sensing_q <= (state_d == ST_SENSE);
    end
  end

  assign bank_sel = bank_q;
  assign charge   = charge_q;
  assign sensing  = sensing_q;
  assign count    = count_q;
  assign avail    = avail_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rcc_scan_ctl.sv
// Self-checking bench for rcc_scan_ctl: scenario tasks with a completion scoreboard.
`timescale 1ns/1ps
module tb_rcc_scan_ctl;

  localparam int NBANK     = 4;
  localparam int CNTW      = 8;
  localparam int CHG_TICKS = 2;
  localparam int BW        = $clog2(NBANK);
  localparam int FULL_CYC  = 2**CNTW;
  localparam int CMAX      = 2**CNTW - 1;

  logic             clk = 1'b0;
  logic             RST_I = 1'b0;
  logic             m10_tick = 1'b0;
  logic             u10_tick = 1'b0;
  logic             cnt_tick = 1'b0;
  logic [3:0]       cfg_poll = 4'd0;
  logic [NBANK-1:0] cfg_mask = '0;
  logic             bank_alldone = 1'b0;
  logic [NBANK-1:0] host_ack = '0;
  logic [BW-1:0]    bank_sel;
  logic             charge;
  logic             sensing;
  logic [CNTW-1:0]  count;
  logic [NBANK-1:0] avail;
  logic [NBANK-1:0] overrun;
  logic             busy;

  rcc_scan_ctl #(.NBANK(NBANK), .CNTW(CNTW), .CHG_TICKS(CHG_TICKS)) dut (
    .CLK_I        (clk),
    .RST_I        (RST_I),
    .m10_tick     (m10_tick),
    .u10_tick     (u10_tick),
    .cnt_tick     (cnt_tick),
    .cfg_poll     (cfg_poll),
    .cfg_mask     (cfg_mask),
    .bank_alldone (bank_alldone),
    .host_ack     (host_ack),
    .bank_sel     (bank_sel),
    .charge       (charge),
    .sensing      (sensing),
    .count        (count),
    .avail        (avail),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               bank;
    int               cnt;
    int               cyc;
    logic [NBANK-1:0] av;
    logic [NBANK-1:0] ov;
  } exp_t;

  exp_t             exp_q[$];
  logic [NBANK-1:0] model_avail = '0;
  logic [NBANK-1:0] model_ovr = '0;
  int               checks = 0;
  int               errors = 0;

  // Observations captured by drive_bank.
  logic [BW-1:0]    obs_bank;
  logic [CNTW-1:0]  obs_count;
  logic [NBANK-1:0] obs_avail;
  logic [NBANK-1:0] obs_ovr;
  int               obs_cycles;
  logic             obs_chg_ok;
  logic             mask_pending = 1'b0;
  logic [NBANK-1:0] mask_new = '0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    RST_I = 1'b0;
    step();
    step();
    RST_I = 1'b1;
    model_avail = '0;
    model_ovr   = '0;
    exp_q.delete();
  endtask

  task automatic pulse_m10();
    m10_tick = 1'b1;
    step();
    m10_tick = 1'b0;
  endtask

  task automatic wait_start(input int maxp, output int np);
    np = 0;
    while (charge !== 1'b1 && np < maxp) begin
      pulse_m10();
      np++;
    end
  endtask

  // Reference model of a bank completion with an optional coincident host ack.
  task automatic push_exp(input int b, input int c, input int cy, input logic [NBANK-1:0] a);
    exp_t e;
    logic [NBANK-1:0] av;
    logic [NBANK-1:0] ov;
    av = model_avail & ~a;
    ov = model_ovr & ~a;
    if (model_avail[b] && !a[b]) ov[b] = 1'b1;
    av[b] = 1'b1;
    model_avail = av;
    model_ovr   = ov;
    e.bank = b; e.cnt = c; e.cyc = cy; e.av = av; e.ov = ov;
    exp_q.push_back(e);
  endtask

  // Drives one bank from CHARGE through SENSE; early mode ends it with bank_alldone
  // after n_cnt count ticks, otherwise count ticks run until the counter saturates.
  task automatic drive_bank(input int n_cnt, input bit early, input logic [NBANK-1:0] ack);
    int last;
    obs_chg_ok = 1'b1;
    for (int c = 0; c < CHG_TICKS; c++) begin
      if (charge !== 1'b1 || sensing !== 1'b0) obs_chg_ok = 1'b0;
      u10_tick = 1'b1;
      step();
      u10_tick = 1'b0;
      if (c < CHG_TICKS - 1) step();
    end
    if (sensing !== 1'b1 || charge !== 1'b0 || count !== '0) obs_chg_ok = 1'b0;
    last = early ? n_cnt : FULL_CYC - 1;
    obs_cycles = 0;
    obs_bank = bank_sel;
    while (sensing === 1'b1 && obs_cycles < FULL_CYC + 8) begin
      if (early && obs_cycles == n_cnt) bank_alldone = 1'b1;
      else cnt_tick = 1'b1;
      if (obs_cycles == last) host_ack = ack;
      if (obs_cycles == 0 && mask_pending) begin
        cfg_mask = mask_new;
        mask_pending = 1'b0;
      end
      obs_bank = bank_sel;
      step();
      obs_cycles++;
      cnt_tick = 1'b0;
      bank_alldone = 1'b0;
      host_ack = '0;
    end
    obs_count = count;
    obs_avail = avail;
    obs_ovr   = overrun;
    $display("bank %0d done: count=%0d sense_cycles=%0d avail=%b overrun=%b",
             obs_bank, obs_count, obs_cycles, obs_avail, obs_ovr);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({charge, sensing, busy, bank_sel, count, avail, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_state: got charge=%b sensing=%b busy=%b bank_sel=%0d count=%0d avail=%b overrun=%b, required all 0",
               charge, sensing, busy, bank_sel, count, avail, overrun);
    end
  endtask

  task automatic test_scan_basic();
    exp_t e;
    bit first;
    do_reset();
    cfg_poll = 4'd2;
    cfg_mask = 4'b0101;
    pulse_m10();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL poll_first_tick: busy=%b, required 0", busy);
    end
    pulse_m10();
    checks++;
    if (charge !== 1'b1 || busy !== 1'b1 || bank_sel !== '0) begin
      errors++;
      $display("FAIL poll_start: charge=%b busy=%b bank_sel=%0d, required 1 1 0", charge, busy, bank_sel);
    end
    first = 1'b1;
    for (int b = 0; b < NBANK; b++) begin
      if (cfg_mask[b]) begin
        if (!first) begin
          step();
          checks++;
          if (charge !== 1'b1 || bank_sel !== BW'(b)) begin
            errors++;
            $display("FAIL basic_next_bank: charge=%b bank_sel=%0d, required 1 %0d", charge, bank_sel, b);
          end
        end
        first = 1'b0;
        push_exp(b, CMAX, FULL_CYC, '0);
        drive_bank(0, 1'b0, '0);
        e = exp_q.pop_front();
        checks++;
        if (obs_chg_ok !== 1'b1) begin
          errors++;
          $display("FAIL basic_charge_phase bank %0d: phase ok=%b, required 1", b, obs_chg_ok);
        end
        checks++;
        if (obs_bank !== BW'(e.bank) || obs_count !== CNTW'(e.cnt) || obs_cycles != e.cyc ||
            obs_avail !== e.av || obs_ovr !== e.ov) begin
          errors++;
          $display("FAIL basic_done bank %0d: got bank=%0d count=%0d cycles=%0d avail=%b ovr=%b, required %0d %0d %0d %b %b",
                   b, obs_bank, obs_count, obs_cycles, obs_avail, obs_ovr, e.bank, e.cnt, e.cyc, e.av, e.ov);
        end
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || avail !== 4'b0101 || overrun !== '0) begin
      errors++;
      $display("FAIL basic_end: busy=%b avail=%b overrun=%b, required 0 0101 0000", busy, avail, overrun);
    end
  endtask

  task automatic test_alldone();
    exp_t e;
    int np;
    do_reset();
    cfg_poll = 4'd1;
    cfg_mask = 4'b0001;
    wait_start(3, np);
    push_exp(0, 17, 18, '0);
    drive_bank(17, 1'b1, '0);
    e = exp_q.pop_front();
    checks++;
    if (obs_count !== CNTW'(e.cnt) || obs_cycles != e.cyc || obs_avail !== e.av || obs_ovr !== e.ov) begin
      errors++;
      $display("FAIL alldone_done: got count=%0d cycles=%0d avail=%b ovr=%b, required %0d %0d %b %b",
               obs_count, obs_cycles, obs_avail, obs_ovr, e.cnt, e.cyc, e.av, e.ov);
    end
    checks++;
    if (busy !== 1'b1 || sensing !== 1'b0 || charge !== 1'b0) begin
      errors++;
      $display("FAIL alldone_next: busy=%b sensing=%b charge=%b, required 1 0 0", busy, sensing, charge);
    end
    step();
    checks++;
    if (busy !== 1'b0 || count !== 8'd17) begin
      errors++;
      $display("FAIL alldone_idle: busy=%b count=%0d, required 0 17", busy, count);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    int np;
    bit first;
    do_reset();
    cfg_poll = 4'd1;
    cfg_mask = 4'b1011;
    for (int s = 0; s < 2; s++) begin
      wait_start(3, np);
      checks++;
      if (charge !== 1'b1 || np != 1) begin
        errors++;
        $display("FAIL overrun_scan_start %0d: charge=%b m10_pulses=%0d, required 1 1", s, charge, np);
      end
      first = 1'b1;
      for (int b = 0; b < NBANK; b++) begin
        if (cfg_mask[b]) begin
          if (!first) step();
          first = 1'b0;
          push_exp(b, 3 + b, 4 + b, '0);
          drive_bank(3 + b, 1'b1, '0);
          e = exp_q.pop_front();
          checks++;
          if (obs_bank !== BW'(e.bank) || obs_count !== CNTW'(e.cnt) || obs_cycles != e.cyc ||
              obs_avail !== e.av || obs_ovr !== e.ov) begin
            errors++;
            $display("FAIL overrun_done scan %0d bank %0d: got bank=%0d count=%0d cycles=%0d avail=%b ovr=%b, required %0d %0d %0d %b %b",
                     s, b, obs_bank, obs_count, obs_cycles, obs_avail, obs_ovr, e.bank, e.cnt, e.cyc, e.av, e.ov);
          end
        end
      end
      step();
    end
    checks++;
    if (overrun !== 4'b1011 || avail !== 4'b1011 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_after_two: overrun=%b avail=%b busy=%b, required 1011 1011 0", overrun, avail, busy);
    end
    host_ack = 4'b0001;
    step();
    host_ack = '0;
    model_avail &= ~4'b0001;
    model_ovr   &= ~4'b0001;
    checks++;
    if (avail !== model_avail || overrun !== model_ovr) begin
      errors++;
      $display("FAIL overrun_ack: avail=%b overrun=%b, required %b %b", avail, overrun, model_avail, model_ovr);
    end
  endtask

  task automatic test_ack_coincident();
    exp_t e;
    int np;
    do_reset();
    cfg_poll = 4'd1;
    cfg_mask = 4'b0001;
    for (int s = 0; s < 2; s++) begin
      wait_start(3, np);
      push_exp(0, 5, 6, (s == 1) ? 4'b0001 : 4'b0000);
      drive_bank(5, 1'b1, (s == 1) ? 4'b0001 : 4'b0000);
      e = exp_q.pop_front();
      checks++;
      if (obs_avail !== e.av || obs_ovr !== e.ov || obs_count !== CNTW'(e.cnt)) begin
        errors++;
        $display("FAIL ack_coincident scan %0d: avail=%b ovr=%b count=%0d, required %b %b %0d",
                 s, obs_avail, obs_ovr, obs_count, e.av, e.ov, e.cnt);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int np;
    bit bad;
    do_reset();
    cfg_poll = 4'd1;
    cfg_mask = 4'b0001;
    wait_start(3, np);
    push_exp(0, 4, 5, '0);
    drive_bank(4, 1'b1, '0);
    e = exp_q.pop_front();
    checks++;
    if (obs_avail !== e.av) begin
      errors++;
      $display("FAIL rstmid_pre_avail: avail=%b, required %b", obs_avail, e.av);
    end
    step();
    wait_start(3, np);
    for (int c = 0; c < CHG_TICKS; c++) begin
      u10_tick = 1'b1;
      step();
      u10_tick = 1'b0;
    end
    cnt_tick = 1'b1;
    for (int i = 0; i < 100; i++) step();
    cnt_tick = 1'b0;
    checks++;
    if (sensing !== 1'b1 || count !== 8'd100) begin
      errors++;
      $display("FAIL rstmid_count: sensing=%b count=%0d, required 1 100", sensing, count);
    end
    RST_I = 1'b0;
    step();
    RST_I = 1'b1;
    model_avail = '0;
    model_ovr   = '0;
    checks++;
    if ({charge, sensing, busy, bank_sel, count, avail, overrun} !== '0) begin
      errors++;
      $display("FAIL rstmid_state: charge=%b sensing=%b busy=%b bank_sel=%0d count=%0d avail=%b overrun=%b, required all 0",
               charge, sensing, busy, bank_sel, count, avail, overrun);
    end
    cfg_poll = 4'd0;
    cfg_mask = 4'b1111;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pulse_m10();
      if (busy !== 1'b0 || charge !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL poll_off: scan seen=%b, required 0", bad);
    end
    cfg_poll = 4'd2;
    pulse_m10();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL poll_held_first: busy=%b, required 0", busy);
    end
    pulse_m10();
    checks++;
    if (charge !== 1'b1 || bank_sel !== '0) begin
      errors++;
      $display("FAIL poll_held_start: charge=%b bank_sel=%0d, required 1 0", charge, bank_sel);
    end
  endtask

  task automatic test_mask_change();
    exp_t e;
    int np;
    do_reset();
    cfg_poll = 4'd1;
    cfg_mask = 4'b1111;
    wait_start(3, np);
    push_exp(0, 2, 3, '0);
    drive_bank(2, 1'b1, '0);
    e = exp_q.pop_front();
    checks++;
    if (obs_bank !== BW'(e.bank) || obs_count !== CNTW'(e.cnt) || obs_avail !== e.av) begin
      errors++;
      $display("FAIL mask_bank0: bank=%0d count=%0d avail=%b, required %0d %0d %b",
               obs_bank, obs_count, obs_avail, e.bank, e.cnt, e.av);
    end
    step();
    checks++;
    if (charge !== 1'b1 || bank_sel !== 2'd1) begin
      errors++;
      $display("FAIL mask_bank1_start: charge=%b bank_sel=%0d, required 1 1", charge, bank_sel);
    end
    mask_pending = 1'b1;
    mask_new = 4'b0001;
    push_exp(1, 4, 5, '0);
    drive_bank(4, 1'b1, '0);
    e = exp_q.pop_front();
    checks++;
    if (obs_bank !== BW'(e.bank) || obs_count !== CNTW'(e.cnt) || obs_cycles != e.cyc || obs_avail !== e.av) begin
      errors++;
      $display("FAIL mask_bank1_done: bank=%0d count=%0d cycles=%0d avail=%b, required %0d %0d %0d %b",
               obs_bank, obs_count, obs_cycles, obs_avail, e.bank, e.cnt, e.cyc, e.av);
    end
    step();
    checks++;
    if (busy !== 1'b0 || charge !== 1'b0 || avail !== 4'b0011) begin
      errors++;
      $display("FAIL mask_skip: busy=%b charge=%b avail=%b, required 0 0 0011", busy, charge, avail);
    end
  endtask

  task automatic test_poll_wrap();
    int np;
    do_reset();
    cfg_poll = 4'd5;
    cfg_mask = 4'b0001;
    pulse_m10();
    pulse_m10();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pre: busy=%b, required 0", busy);
    end
    cfg_poll = 4'd2;
    wait_start(40, np);
    checks++;
    if (charge !== 1'b1 || np != 16) begin
      errors++;
      $display("FAIL wrap_start: charge=%b m10_pulses=%0d, required 1 16", charge, np);
    end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_alldone();
    test_overrun();
    test_ack_coincident();
    test_reset_mid();
    test_mask_change();
    test_poll_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
